// File: rtl/mem_pkg.sv
// Shared constants, FSM state encodings and address helpers for the
// instruction-cache backing memory and the cache line-fill logic.
package mem_pkg;

  localparam int ADDR_W = 20;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W+3:4];
  endfunction

  function automatic logic [1:0] word_sel(input logic [ADDR_W-1:0] addr);
    return addr[3:2];
  endfunction

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:4], 4'b0000};
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Pending line-request FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module req_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) slot_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

  assign data_o = slot_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/mem_line_responder.sv
// Backing-memory responder for the I-cache line fill: queued line requests
// answered after LATENCY cycles, plus a 32-bit store-path write port.
module mem_line_responder #(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int LINE_W  = mem_pkg::LINE_W,
  parameter int IDX_W   = mem_pkg::IDX_W,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 2
`ifdef MEM_PRELOAD_EN
  , parameter string INIT_FILE = "mem_init.hex"
`endif
) (
  input  logic                       clk_i,
  input  logic                       rsn_i,
  input  logic                       rqst_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [mem_pkg::WORD_W-1:0] wr_data_i,
  output logic                       mem_data_ready_o,
  output logic [LINE_W-1:0]          mem_data_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic                       busy_o,
  output logic                       ovf_o
);

  import mem_pkg::*;

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LINE_W-1:0] data_hold_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic              ovf_q;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [ADDR_W-1:0] fifo_head;

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [1:0]        wr_word;
  logic [LINE_W-1:0] rd_line;
  logic [ADDR_W-1:0] resp_addr;
  logic              unused_bits;

  logic [LINE_W-1:0] mem_q [DEPTH] = '{default: '0};

  req_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .push_i  (rqst_i),
    .data_i  (addr_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The head is taken whenever the FSM is free to start a new request.
  assign fifo_pop = ((state_q == IDLE) || (state_q == RESP)) && !fifo_empty;

  // Upper address bits are not decoded: storage aliases modulo DEPTH lines.
  assign rd_idx    = cur_addr_q[IDX_W+3:4];
  assign wr_idx    = wr_addr_i[IDX_W+3:4];
  assign wr_word   = wr_addr_i[3:2];
  assign rd_line   = mem_q[rd_idx];
  assign resp_addr = {cur_addr_q[ADDR_W-1:4], 4'b0000};

  assign unused_bits = ^{wr_addr_i[1:0], wr_addr_i[ADDR_W-1:IDX_W+4], cur_addr_q[3:0]};

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      data_hold_q <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rqst_i && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      if (state_q == RESP) begin
        data_hold_q <= rd_line;
        addr_hold_q <= resp_addr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    cur_addr_q <= cur_addr_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    case (state_q)
      IDLE, RESP: begin
        if (!fifo_empty) begin
          state_d    = WAIT;
          cnt_d      = CNT_W'(LATENCY - 1);
          cur_addr_d = fifo_head;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Read happens combinationally in RESP, so a same-edge write lands after it.
  always_comb begin
    mem_data_ready_o = 1'b0;
    mem_data_o       = data_hold_q;
    mem_addr_o       = addr_hold_q;
    if (state_q == RESP) begin
      mem_data_ready_o = 1'b1;
      mem_data_o       = rd_line;
      mem_addr_o       = resp_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx][{wr_word, 5'd0} +: WORD_W] <= wr_data_i;
  end

  assign busy_o = !fifo_empty || (state_q != IDLE);
  assign ovf_o  = ovf_q;

endmodule
